alarm_sequencer: RTL and testbench

Multi-zone arming and alarm sequencer sitting above the single-sensor security FSM in the alarm chip. It arms and disarms the system from a keypad code, runs exit and entry delays, times the siren and latches which zones tripped. It supervises up to `ZONES` sensor inputs and owns the single siren output.

---
 rtl/alarm_pkg.sv | 22 ++
 rtl/alarm_sequencer_delay_timer.sv | 27 ++
 rtl/alarm_sequencer.sv | 174 +++++++++++++++++
 tb/tb_alarm_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared encodings for the alarm sequencer: state codes and a sizing helper
// for the shared delay counter.
package alarm_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_DISARMED  = 3'd0,
        S_EXIT_DLY  = 3'd1,
        S_ARMED     = 3'd2,
        S_ENTRY_DLY = 3'd3,
        S_ALARM     = 3'd4,
        S_HOLDOFF   = 3'd5
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/alarm_sequencer_delay_timer.sv
// Loadable down-counter shared by the exit, entry and siren phases.
// Stops at zero rather than wrapping.
module delay_timer #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic          zero
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (load)
            r_cnt <= load_val;
        else if (en && r_cnt != '0)
            r_cnt <= r_cnt - CW'(1);
    end

    assign zero = (r_cnt == '0);

endmodule

// File: rtl/alarm_sequencer.sv
// Multi-zone arm/disarm sequencer: exit and entry delays, siren timing,
// tripped-zone latch and wrong-code lockout into ALARM.
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int         ZONES     = 4,
    parameter int         EXIT_CYC  = 16,
    parameter int         ENTRY_CYC = 8,
    parameter int         SIREN_CYC = 32,
    parameter logic [3:0] CODE      = 4'hA,
    parameter int         MAX_BAD   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arm_req,
    input  logic               code_vld,
    input  logic [3:0]         code_in,
    input  logic [ZONES-1:0]   zone_in,
    input  logic [ZONES-1:0]   zone_mask,
    output logic               siren,
    output logic               armed,
    output logic [STATE_W-1:0] state_o,
    output logic [ZONES-1:0]   tripped,
    output logic               code_err,
    output logic               arm_fail
);

    localparam int CW_RAW = $clog2(max3(EXIT_CYC, ENTRY_CYC, SIREN_CYC));
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] EXIT_LD  = CW'(EXIT_CYC - 1);
    localparam logic [CW-1:0] ENTRY_LD = CW'(ENTRY_CYC - 1);
    localparam logic [CW-1:0] SIREN_LD = CW'(SIREN_CYC - 1);
    localparam logic [2:0]    BAD_MAX  = 3'(MAX_BAD);

    state_e           r_state;
    logic [ZONES-1:0] r_tripped;
    logic [2:0]       r_bad_cnt;
    logic             r_code_err;
    logic             r_arm_fail;

    logic [ZONES-1:0] w_act;
    logic             w_good;
    logic             w_bad;
    logic [2:0]       w_bad_inc;
    logic             w_force;
    logic             w_zero;
    logic             w_load;
    logic [CW-1:0]    w_load_val;
    logic             w_en;

    assign w_act     = zone_in & ~zone_mask;
    assign w_good    = code_vld && (code_in == CODE);
    assign w_bad     = code_vld && (code_in != CODE);
    assign w_bad_inc = (r_bad_cnt == BAD_MAX) ? r_bad_cnt : r_bad_cnt + 3'd1;
    assign w_force   = w_bad && (w_bad_inc == BAD_MAX) &&
                       (r_state == S_ARMED || r_state == S_ENTRY_DLY);

    // Timer control mirrors the FSM transitions below; every entry into
    // ALARM (timeout, forced or retrigger) reloads the siren length.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        w_en       = 1'b0;
        case (r_state)
            S_DISARMED: if (arm_req && w_act == '0) begin
                w_load     = 1'b1;
                w_load_val = EXIT_LD;
            end
            S_EXIT_DLY: w_en = !w_good;
            S_ARMED: if (!w_good) begin
                if (w_force) begin
                    w_load     = 1'b1;
                    w_load_val = SIREN_LD;
                end else if (w_act != '0) begin
                    w_load     = 1'b1;
                    w_load_val = ENTRY_LD;
                end
            end
            S_ENTRY_DLY: if (!w_good) begin
                if (w_force || w_zero) begin
                    w_load     = 1'b1;
                    w_load_val = SIREN_LD;
                end else begin
                    w_en = 1'b1;
                end
            end
            S_ALARM: w_en = !w_good;
            S_HOLDOFF: if (!w_good && (w_act & ~r_tripped) != '0) begin
                w_load     = 1'b1;
                w_load_val = SIREN_LD;
            end
            default: ;
        endcase
    end

    delay_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .en       (w_en),
        .zero     (w_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_DISARMED;
            r_tripped  <= '0;
            r_bad_cnt  <= '0;
            r_code_err <= 1'b0;
            r_arm_fail <= 1'b0;
        end else begin
            r_code_err <= w_bad;
            r_arm_fail <= 1'b0;
            if (r_state == S_ARMED || r_state == S_ENTRY_DLY ||
                r_state == S_ALARM || r_state == S_HOLDOFF)
                r_tripped <= r_tripped | w_act;
            if (w_good)
                r_bad_cnt <= '0;
            else if (w_bad && r_state != S_DISARMED)
                r_bad_cnt <= w_bad_inc;

            case (r_state)
                S_DISARMED: begin
                    r_bad_cnt <= '0;
                    if (arm_req) begin
                        if (w_act == '0) begin
                            r_state   <= S_EXIT_DLY;
                            r_tripped <= '0;
                        end else begin
                            r_arm_fail <= 1'b1;
                        end
                    end
                end
                S_EXIT_DLY: begin
                    if (w_good)      r_state <= S_DISARMED;
                    else if (w_zero) r_state <= S_ARMED;
                end
                S_ARMED: begin
                    if (w_good)              r_state <= S_DISARMED;
                    else if (w_force)        r_state <= S_ALARM;
                    else if (w_act != '0)    r_state <= S_ENTRY_DLY;
                end
                S_ENTRY_DLY: begin
                    if (w_good)              r_state <= S_DISARMED;
                    else if (w_force)        r_state <= S_ALARM;
                    else if (w_zero)         r_state <= S_ALARM;
                end
                S_ALARM: begin
                    if (w_good)      r_state <= S_DISARMED;
                    else if (w_zero) r_state <= S_HOLDOFF;
                end
                S_HOLDOFF: begin
                    if (w_good)                              r_state <= S_DISARMED;
                    else if ((w_act & ~r_tripped) != '0)     r_state <= S_ALARM;
                end
                default: begin
                    r_state   <= S_DISARMED;
                    r_bad_cnt <= '0;
                end
            endcase
            if (w_good) r_bad_cnt <= '0;
        end
    end

    assign state_o  = r_state;
    assign siren    = (r_state == S_ALARM);
    assign armed    = (r_state == S_ARMED) || (r_state == S_ENTRY_DLY) ||
                      (r_state == S_ALARM) || (r_state == S_HOLDOFF);
    assign tripped  = r_tripped;
    assign code_err = r_code_err;
    assign arm_fail = r_arm_fail;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Scenario bench for alarm_sequencer at default parameters: expected
// per-cycle states are queued with the stimulus and popped as cycles elapse.
module tb_alarm_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       arm_req;
    logic       code_vld;
    logic [3:0] code_in;
    logic [3:0] zone_in;
    logic [3:0] zone_mask;
    logic       siren;
    logic       armed;
    logic [2:0] state_o;
    logic [3:0] tripped;
    logic       code_err;
    logic       arm_fail;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [2:0] st;
        logic [3:0] trip;
    } exp_t;
    exp_t sb[$];

    alarm_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .arm_req   (arm_req),
        .code_vld  (code_vld),
        .code_in   (code_in),
        .zone_in   (zone_in),
        .zone_mask (zone_mask),
        .siren     (siren),
        .armed     (armed),
        .state_o   (state_o),
        .tripped   (tripped),
        .code_err  (code_err),
        .arm_fail  (arm_fail)
    );

    always #5 clk = ~clk;

    function automatic void push(input logic [2:0] s, input logic [3:0] t, input int n);
        exp_t e;
        e.st   = s;
        e.trip = t;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_armed();
        zone_in = 4'b0000;
        arm_req = 1'b1;
        cyc();
        arm_req = 1'b0;
        repeat (16) cyc();
    endtask

    task automatic disarm();
        code_vld = 1'b1;
        code_in  = 4'hA;
        cyc();
        code_vld = 1'b0;
        code_in  = 4'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1; arm_req = 0; code_vld = 0; code_in = 0; zone_in = 0; zone_mask = 0;
        repeat (2) cyc();
        vectors++;
        if ({state_o, siren, armed, tripped, code_err, arm_fail} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset: got st=%0d siren=%b armed=%b trip=%b err=%b afail=%b, want all 0",
                     state_o, siren, armed, tripped, code_err, arm_fail);
        end
        rst = 1'b0;
        cyc();
        vectors++;
        if ({state_o, armed} !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_release: got st=%0d armed=%b, want 0/0", state_o, armed);
        end
    endtask

    task automatic test_arm_alarm();
        exp_t e;
        zone_in = 4'b0000; zone_mask = 4'b0000; arm_req = 1'b1;
        push(3'd1, 4'b0000, 16);
        push(3'd2, 4'b0000, 1);
        while (sb.size() > 0) begin
            cyc(); arm_req = 1'b0;
            e = sb.pop_front(); vectors++;
            if ({state_o, siren, armed, tripped} !== {e.st, e.st == 3'd4, (e.st >= 3'd2 && e.st <= 3'd5), e.trip}) begin
                miscompares++;
                $display("FAIL arm_exit: got st=%0d siren=%b armed=%b trip=%b, want st=%0d trip=%b",
                         state_o, siren, armed, tripped, e.st, e.trip);
            end
        end
        zone_in = 4'b0010;
        push(3'd3, 4'b0010, 8);
        push(3'd4, 4'b0010, 32);
        push(3'd5, 4'b0010, 4);
        while (sb.size() > 0) begin
            cyc();
            e = sb.pop_front(); vectors++;
            if ({state_o, siren, armed, tripped} !== {e.st, e.st == 3'd4, (e.st >= 3'd2 && e.st <= 3'd5), e.trip}) begin
                miscompares++;
                $display("FAIL arm_alarm: got st=%0d siren=%b armed=%b trip=%b, want st=%0d trip=%b",
                         state_o, siren, armed, tripped, e.st, e.trip);
            end
        end
        zone_in = 4'b0000;
        disarm();
        vectors++;
        if ({state_o, armed, tripped} !== {3'd0, 1'b0, 4'b0010}) begin
            miscompares++;
            $display("FAIL trip_held: got st=%0d armed=%b trip=%b, want st=0 armed=0 trip=0010",
                     state_o, armed, tripped);
        end
    endtask

    task automatic test_arm_refused();
        zone_in = 4'b0001; zone_mask = 4'b0000; arm_req = 1'b1;
        cyc(); arm_req = 1'b0;
        vectors++;
        if ({arm_fail, state_o} !== {1'b1, 3'd0}) begin
            miscompares++;
            $display("FAIL arm_refused: got afail=%b st=%0d, want afail=1 st=0", arm_fail, state_o);
        end
        cyc();
        vectors++;
        if ({arm_fail, state_o} !== {1'b0, 3'd0}) begin
            miscompares++;
            $display("FAIL arm_fail_pulse: got afail=%b st=%0d, want afail=0 st=0", arm_fail, state_o);
        end
        zone_mask = 4'b0001; arm_req = 1'b1;
        cyc(); arm_req = 1'b0;
        vectors++;
        if ({arm_fail, state_o, tripped} !== {1'b0, 3'd1, 4'b0000}) begin
            miscompares++;
            $display("FAIL arm_masked: got afail=%b st=%0d trip=%b, want afail=0 st=1 trip=0000",
                     arm_fail, state_o, tripped);
        end
        disarm();
        zone_in = 4'b0000; zone_mask = 4'b0000;
        vectors++;
        if ({state_o, code_err} !== {3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL exit_disarm: got st=%0d err=%b, want st=0 err=0", state_o, code_err);
        end
    endtask

    task automatic test_entry_disarm();
        exp_t e;
        goto_armed();
        zone_in = 4'b0100;
        push(3'd3, 4'b0100, 8);
        while (sb.size() > 0) begin
            cyc();
            e = sb.pop_front(); vectors++;
            if ({state_o, siren, armed, tripped} !== {e.st, e.st == 3'd4, (e.st >= 3'd2 && e.st <= 3'd5), e.trip}) begin
                miscompares++;
                $display("FAIL entry_wait: got st=%0d siren=%b armed=%b trip=%b, want st=%0d trip=%b",
                         state_o, siren, armed, tripped, e.st, e.trip);
            end
        end
        zone_in = 4'b0000;
        disarm();
        vectors++;
        if ({state_o, siren} !== {3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL entry_disarm: got st=%0d siren=%b, want st=0 siren=0", state_o, siren);
        end
    endtask

    task automatic test_bad_codes();
        logic [3:0] exp_q[$];
        logic [3:0] x;
        goto_armed();
        for (int k = 0; k < 3; k++) begin
            code_vld = 1'b1; code_in = 4'h3;
            exp_q.push_back({1'b1, (k == 2) ? 3'd4 : 3'd2});
            cyc();
            x = exp_q.pop_front(); vectors++;
            if ({code_err, state_o} !== x) begin
                miscompares++;
                $display("FAIL bad_code%0d: got err=%b st=%0d, want err=%b st=%0d",
                         k, code_err, state_o, x[3], x[2:0]);
            end
        end
        code_vld = 1'b0;
        cyc();
        vectors++;
        if ({code_err, state_o, siren} !== {1'b0, 3'd4, 1'b1}) begin
            miscompares++;
            $display("FAIL bad_alarm: got err=%b st=%0d siren=%b, want err=0 st=4 siren=1",
                     code_err, state_o, siren);
        end
        disarm();
        code_vld = 1'b1; code_in = 4'h5;
        cyc();
        code_vld = 1'b0;
        vectors++;
        if ({code_err, state_o} !== {1'b1, 3'd0}) begin
            miscompares++;
            $display("FAIL bad_disarmed: got err=%b st=%0d, want err=1 st=0", code_err, state_o);
        end
    endtask

    task automatic test_holdoff();
        exp_t e;
        goto_armed();
        zone_in = 4'b0010;
        push(3'd3, 4'b0010, 8);
        push(3'd4, 4'b0010, 32);
        push(3'd5, 4'b0010, 3);
        while (sb.size() > 0) begin
            cyc();
            e = sb.pop_front(); vectors++;
            if ({state_o, siren, armed, tripped} !== {e.st, e.st == 3'd4, (e.st >= 3'd2 && e.st <= 3'd5), e.trip}) begin
                miscompares++;
                $display("FAIL holdoff_first: got st=%0d siren=%b armed=%b trip=%b, want st=%0d trip=%b",
                         state_o, siren, armed, tripped, e.st, e.trip);
            end
        end
        zone_in = 4'b0110;
        push(3'd4, 4'b0110, 32);
        push(3'd5, 4'b0110, 2);
        while (sb.size() > 0) begin
            cyc();
            e = sb.pop_front(); vectors++;
            if ({state_o, siren, armed, tripped} !== {e.st, e.st == 3'd4, (e.st >= 3'd2 && e.st <= 3'd5), e.trip}) begin
                miscompares++;
                $display("FAIL holdoff_retrig: got st=%0d siren=%b armed=%b trip=%b, want st=%0d trip=%b",
                         state_o, siren, armed, tripped, e.st, e.trip);
            end
        end
        zone_in = 4'b0000;
        disarm();
    endtask

    task automatic test_reset_alarm();
        goto_armed();
        zone_in = 4'b0001;
        repeat (9) cyc();
        repeat (9) cyc();
        vectors++;
        if ({state_o, siren} !== {3'd4, 1'b1}) begin
            miscompares++;
            $display("FAIL pre_reset_alarm: got st=%0d siren=%b, want st=4 siren=1", state_o, siren);
        end
        rst = 1'b1;
        #2;
        vectors++;
        if ({state_o, siren, armed, tripped, code_err, arm_fail} !== 11'd0) begin
            miscompares++;
            $display("FAIL async_reset: got st=%0d siren=%b armed=%b trip=%b err=%b afail=%b, want all 0",
                     state_o, siren, armed, tripped, code_err, arm_fail);
        end
        cyc();
        rst = 1'b0; zone_in = 4'b0000;
        cyc();
        vectors++;
        if ({state_o, siren} !== {3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL post_reset: got st=%0d siren=%b, want st=0 siren=0", state_o, siren);
        end
    endtask

    initial begin
        test_reset();
        test_arm_alarm();
        test_arm_refused();
        test_entry_disarm();
        test_bad_codes();
        test_holdoff();
        test_reset_alarm();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
